uart_rx_gen: RTL and testbench

Next-generation UART receiver. It is parametrised in data width and FIFO depth, and its baud divisor and frame format (parity, stop bits) are programmable at run time. It detects parity and framing errors, handles breaks, and buffers received characters in a show-ahead FIFO behind a valid/ready handshake. It sits between the asynchronous serial pin and any byte consumer in the same clock domain.

---
 rtl/uart_rx_gen.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_gen.sv
// UART receiver with a run-time baud divisor and frame format.
// It flags parity and framing errors, handles line breaks, and
// buffers received characters in a show-ahead FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | line idle, waiting for a falling edge on rx_s
// START    | timing to the middle of the start bit to reject glitches
// DATA     | sampling DATA_BITS data bits, LSB first
// PARITY   | sampling the parity bit
// STOP1    | sampling the first stop bit
// STOP2    | sampling the second stop bit
// BRK_WAIT | last stop bit was low; waiting for the line to go high
module uart_rx_gen #(
  parameter int DATA_BITS  = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Rx_Serial,
  input  logic [CNT_WIDTH-1:0]          i_Clks_Per_Bit,
  input  logic                          i_Parity_En,
  input  logic                          i_Parity_Odd,
  input  logic                          i_Two_Stop,
  output logic                          o_Rx_Valid,
  input  logic                          i_Rx_Ready,
  output logic [DATA_BITS-1:0]          o_Rx_Data,
  output logic                          o_Parity_Err,
  output logic                          o_Frame_Err,
  output logic                          o_Overrun,
  output logic                          o_Busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DATA_BITS + 2;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT
  } state_t;

  state_t                 state, state_nxt;
  logic                   rx_meta, rx_s;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0]   div_l;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [DATA_BITS-1:0]   shift, shift_nxt;
  logic                   par_en_l, par_odd_l, two_stop_l;
  logic                   perr_r, perr_nxt;
  logic                   ferr1_r, ferr1_nxt;
  logic                   latch_cfg;
  logic                   push;
  logic [ENT_W-1:0]       push_data;
  logic                   bit_end, half_bit;

  logic [ENT_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;
  logic                   full, pop, push_ok;
  logic [ENT_W-1:0]       head;

  assign bit_end  = (cnt == div_l - CNT_WIDTH'(1));
  assign half_bit = (cnt == ((div_l - CNT_WIDTH'(1)) >> 1));

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state and datapath registers; frame format latched at start.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      perr_r     <= 1'b0;
      ferr1_r    <= 1'b0;
      div_l      <= CNT_WIDTH'(2);
      par_en_l   <= 1'b0;
      par_odd_l  <= 1'b0;
      two_stop_l <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      perr_r  <= perr_nxt;
      ferr1_r <= ferr1_nxt;
      if (latch_cfg) begin
        div_l      <= (i_Clks_Per_Bit < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : i_Clks_Per_Bit;
        par_en_l   <= i_Parity_En;
        par_odd_l  <= i_Parity_Odd;
        two_stop_l <= i_Two_Stop;
      end
    end
  end

  // Next-state, bit timing, sampling and frame completion.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    perr_nxt  = perr_r;
    ferr1_nxt = ferr1_r;
    latch_cfg = 1'b0;
    push      = 1'b0;
    push_data = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rx_s) begin
          latch_cfg = 1'b1;
          perr_nxt  = 1'b0;
          ferr1_nxt = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (half_bit) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_s;
          if (idx == IDX_W'(DATA_BITS - 1)) begin
            idx_nxt   = '0;
            state_nxt = par_en_l ? PARITY : STOP1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          perr_nxt  = ((^shift) ^ rx_s) != par_odd_l;
          state_nxt = STOP1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      STOP1: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (two_stop_l) begin
            ferr1_nxt = ~rx_s;
            state_nxt = STOP2;
          end else begin
            push      = 1'b1;
            push_data = {~rx_s, perr_r, shift};
            state_nxt = rx_s ? IDLE : BRK_WAIT;
          end
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      STOP2: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          push      = 1'b1;
          push_data = {ferr1_r | ~rx_s, perr_r, shift};
          state_nxt = rx_s ? IDLE : BRK_WAIT;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      BRK_WAIT: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop     = (count != '0) && i_Rx_Ready;
  assign push_ok = push && (!full || pop);
  assign head    = mem[rd_ptr];

  // FIFO storage; contents are only observable through the valid-gated head.
  always_ff @(posedge i_Clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and the overrun pulse.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_Overrun <= 1'b0;
    end else begin
      o_Overrun <= push && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_Rx_Valid   = (count != '0);
  assign o_Rx_Data    = o_Rx_Valid ? head[DATA_BITS-1:0] : '0;
  assign o_Parity_Err = o_Rx_Valid & head[DATA_BITS];
  assign o_Frame_Err  = o_Rx_Valid & head[DATA_BITS+1];
  assign o_Busy       = (state != IDLE);
  assign o_Fifo_Count = count;

endmodule

// File: tb/tb_uart_rx_gen.sv
// Self-checking bench for uart_rx_gen: a scoreboard of expected
// {ferr, perr, data} entries is filled by the serial driver and
// drained by a monitor watching the valid/ready handshake.
module tb_uart_rx_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] clks_per_bit = 16'd16;
  logic        par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0;
  logic        rx_ready = 1'b0;
  logic        rx_valid, parity_err, frame_err, overrun, busy;
  logic [7:0]  rx_data;
  logic [2:0]  fifo_count;

  int          cyc = 0;
  int          n_checks = 0, n_pass = 0;
  int          n_pops = 0, n_ovr = 0, last_pop_cyc = 0, t_start = 0;
  logic [9:0]  sb [$];

  uart_rx_gen #(.DATA_BITS(8), .CNT_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_Rx_Serial    (rx),
    .i_Clks_Per_Bit (clks_per_bit),
    .i_Parity_En    (par_en),
    .i_Parity_Odd   (par_odd),
    .i_Two_Stop     (two_stop),
    .o_Rx_Valid     (rx_valid),
    .i_Rx_Ready     (rx_ready),
    .o_Rx_Data      (rx_data),
    .o_Parity_Err   (parity_err),
    .o_Frame_Err    (frame_err),
    .o_Overrun      (overrun),
    .o_Busy         (busy),
    .o_Fifo_Count   (fifo_count)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Pop the scoreboard whenever the DUT hands over an entry.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_entry", sb.size(), 1);
      end else begin
        check("rx_entry", {frame_err, parity_err, rx_data}, sb.pop_front());
      end
      n_pops       <= n_pops + 1;
      last_pop_cyc <= cyc;
    end
  end

  // Count overrun pulses.
  always @(negedge clk) if (rst_n && overrun) n_ovr <= n_ovr + 1;

  task automatic hold_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; abort_bit >= 0 stops halfway through that data bit.
  task automatic send_frame(input logic [7:0] d, input int div, input bit pen,
                            input bit podd, input bit two, input bit pflip,
                            input bit stop2_val, input bit expect_push,
                            input int abort_bit);
    logic pbit;
    @(negedge clk);
    clks_per_bit = 16'(div);
    par_en = pen; par_odd = podd; two_stop = two;
    if (expect_push) sb.push_back({two & ~stop2_val, pen & pflip, d});
    t_start = cyc;
    hold_bit(1'b0, div);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        hold_bit(d[i], div / 2);
        return;
      end
      hold_bit(d[i], div);
    end
    pbit = (podd ? ~(^d) : (^d)) ^ pflip;
    if (pen) hold_bit(pbit, div);
    hold_bit(1'b1, div);
    if (two) hold_bit(stop2_val, div);
    hold_bit(1'b1, 2 * div);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    int p0, o0, bc, lat;
    #1;
    check("reset_outputs", {rx_valid, rx_data, parity_err, frame_err, overrun, busy, fifo_count}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {rx_valid, rx_data, parity_err, frame_err, overrun, busy, fifo_count}, 0);

    // 8N1, div 16, 0xA5
    rx_ready = 1'b1;
    send_frame(8'hA5, 16, 0, 0, 0, 0, 1, 1, -1);
    wait_drain("t1_drain");
    lat = last_pop_cyc - t_start;
    check("t1_latency_in_range", (lat >= 150 && lat <= 160), 1);
    @(negedge clk);
    check("t1_valid_single_cycle", rx_valid, 0);

    // 8E1, div 10, good then bad parity
    send_frame(8'h3C, 10, 1, 0, 0, 0, 1, 1, -1);
    wait_drain("t2_good_parity_drain");
    send_frame(8'h3C, 10, 1, 0, 0, 1, 1, 1, -1);
    wait_drain("t2_bad_parity_drain");

    // 8N2, div 8, bad second stop, then a break
    send_frame(8'h55, 8, 0, 0, 1, 0, 0, 1, -1);
    wait_drain("t3_stop2_drain");
    p0 = n_pops;
    sb.push_back({1'b1, 1'b0, 8'h00});
    @(negedge clk);
    hold_bit(1'b0, 100);
    check("t3_break_one_entry", n_pops - p0, 1);
    check("t3_busy_during_break", busy, 1);
    hold_bit(1'b1, 5);
    check("t3_busy_after_break", busy, 0);
    wait_drain("t3_break_drain");

    // Overrun: 5 frames into a 4-deep FIFO with no consumer
    rx_ready = 1'b0;
    o0 = n_ovr;
    for (int k = 1; k <= 5; k++)
      send_frame(8'(k), 16, 0, 0, 0, 0, 1, (k <= 4), -1);
    check("t4_fifo_full_count", fifo_count, 4);
    check("t4_one_overrun", n_ovr - o0, 1);
    @(negedge clk);
    rx_ready = 1'b1;
    wait_drain("t4_drain_in_order");
    @(negedge clk);
    check("t4_fifo_empty", fifo_count, 0);

    // Glitch rejection
    p0 = n_pops; o0 = n_ovr; bc = 0;
    @(negedge clk);
    hold_bit(1'b0, 3);
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    check("t5_busy_short", (bc > 0 && bc < 12), 1);
    check("t5_no_entry", n_pops - p0, 0);
    check("t5_no_overrun", n_ovr - o0, 0);
    check("t5_fifo_empty", fifo_count, 0);

    // Reset during data bit 4 with two entries queued
    rx_ready = 1'b0;
    send_frame(8'h11, 16, 0, 0, 0, 0, 1, 1, -1);
    send_frame(8'h22, 16, 0, 0, 0, 0, 1, 1, -1);
    check("t6_two_queued", fifo_count, 2);
    send_frame(8'h7E, 16, 0, 0, 0, 0, 1, 0, 4);
    check("t6_busy_mid_frame", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", {rx_valid, rx_data, parity_err, frame_err, overrun, busy, fifo_count}, 0);
    sb.delete();
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h7E, 16, 0, 0, 0, 0, 1, 1, -1);
    wait_drain("t6_after_reset_drain");
    @(negedge clk);
    check("t6_fifo_empty_end", fifo_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
